// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and helpers for the reset sequencer: the FSM
//               state encoding, the timer-width calculation and a lowest-set
//               bit finder used to report which stage lost its ready.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Upper bound on the number of sequenced stages.
    localparam int MAX_STAGES = 16;

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        WAIT_READY = 3'd1,
        GAP        = 3'd2,
        DONE       = 3'd3,
        FAULT      = 3'd4
    } seq_state_t;

    // The timer must be able to hold the larger of the two limits.
    function automatic int timer_width(input int delay_cycles, input int timeout_cycles);
        int max_val;
        max_val = (delay_cycles > timeout_cycles) ? delay_cycles : timeout_cycles;
        return $clog2(max_val + 1);
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [3:0] lowest_set(input logic [MAX_STAGES-1:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : Clearable, saturating up-counter with a terminal-count
//               compare against a runtime limit.
// Ports       : clk     - system clock
//               rst     - synchronous active-high reset
//               i_clear - restart counting from zero on the next edge
//               i_limit - number of edges to count (>= 1)
//               o_done  - high on the edge that completes i_limit counts
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] c_count_max = '1;

    logic [WIDTH-1:0] r_count;

    // Saturates at all-ones so a long stay in DONE/FAULT can never wrap.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (r_count != c_count_max) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Count value k is seen on the (k+1)-th edge after a clear, so the
    // limit-th edge is the one that observes limit-1.
    assign o_done = (r_count >= (i_limit - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Releases NUM_STAGES subsystem resets one at a time in index
//               order. Each released stage must report ready before the next
//               is released; a missing or lost ready forces every stage back
//               into reset and raises a sticky fault.
// Ports       : clock        - system clock
//               reset        - synchronous active-high reset
//               restart      - one-cycle pulse, reruns the sequence
//               stage_ready  - per-stage ready inputs
//               stage_reset  - per-stage resets, active-high, registered
//               all_ready    - every stage released and ready
//               fault        - sticky error flag
//               fault_stage  - index of the stage that caused the fault
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int DELAY_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  restart,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  all_ready,
    output logic                  fault,
    output logic [IDX_W-1:0]      fault_stage
);

    localparam int TIMER_W = timer_width(DELAY_CYCLES, TIMEOUT_CYCLES);

    localparam logic [TIMER_W-1:0] c_delay_limit   = TIMER_W'(DELAY_CYCLES);
    localparam logic [TIMER_W-1:0] c_timeout_limit = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0]   c_last_idx      = IDX_W'(NUM_STAGES - 1);

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_next_idx;

    logic [NUM_STAGES-1:0]  r_stage_reset;
    logic                   r_all_ready;
    logic                   r_fault;
    logic [IDX_W-1:0]       r_fault_stage;

    logic [NUM_STAGES-1:0]  w_stage_reset_nxt;
    logic                   w_all_ready_nxt;
    logic                   w_fault_nxt;
    logic [IDX_W-1:0]       w_fault_stage_nxt;

    logic                   w_timer_clear;
    logic                   w_timer_done;
    logic [TIMER_W-1:0]     w_timer_limit;

    logic [NUM_STAGES-1:0]  w_released;
    logic [NUM_STAGES-1:0]  w_lost;
    logic                   w_lost_any;
    logic [IDX_W-1:0]       w_lost_idx;
    logic                   w_ready_cur;
    logic                   w_is_last;

    // ------------------------------------------------------------------
    // Shared delay / timeout timer
    // ------------------------------------------------------------------
    // Every state change restarts the count, so HOLD, GAP and WAIT_READY
    // each measure from their own entry edge.
    assign w_timer_clear = restart || (w_next_state != r_state);
    assign w_timer_limit = (r_state == WAIT_READY) ? c_timeout_limit : c_delay_limit;

    seq_timer #(
        .WIDTH   (TIMER_W)
    ) u_timer (
        .clk     (clock),
        .rst     (reset),
        .i_clear (w_timer_clear),
        .i_limit (w_timer_limit),
        .o_done  (w_timer_done)
    );

    // ------------------------------------------------------------------
    // Lost-ready detection
    // ------------------------------------------------------------------
    // Stages below idx have already been accepted as ready; in DONE every
    // stage has. Stages still held in reset are never monitored.
    always_comb begin
        w_released = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_state == DONE) begin
                w_released[i] = 1'b1;
            end else if ((r_state == WAIT_READY) || (r_state == GAP)) begin
                w_released[i] = (IDX_W'(i) < r_idx);
            end
        end
    end

    assign w_lost      = w_released & ~stage_ready;
    assign w_lost_any  = |w_lost;
    assign w_lost_idx  = IDX_W'(lowest_set(MAX_STAGES'(w_lost)));
    assign w_ready_cur = stage_ready[r_idx];
    assign w_is_last   = (r_idx == c_last_idx);

    // ------------------------------------------------------------------
    // State register, index and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= HOLD;
            r_idx         <= '0;
            r_stage_reset <= '1;
            r_all_ready   <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else begin
            r_state       <= w_next_state;
            r_idx         <= w_next_idx;
            r_stage_reset <= w_stage_reset_nxt;
            r_all_ready   <= w_all_ready_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_stage <= w_fault_stage_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: restart > lost ready > ready > timeout
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        if (restart) begin
            w_next_state = HOLD;
            w_next_idx   = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_timer_done) begin
                        w_next_state = WAIT_READY;
                    end
                end
                WAIT_READY: begin
                    if (w_lost_any) begin
                        w_next_state = FAULT;
                    end else if (w_ready_cur) begin
                        if (w_is_last) begin
                            w_next_state = DONE;
                        end else begin
                            w_next_state = GAP;
                            w_next_idx   = r_idx + IDX_W'(1);
                        end
                    end else if (w_timer_done) begin
                        w_next_state = FAULT;
                    end
                end
                GAP: begin
                    if (w_lost_any) begin
                        w_next_state = FAULT;
                    end else if (w_timer_done) begin
                        w_next_state = WAIT_READY;
                    end
                end
                DONE: begin
                    if (w_lost_any) begin
                        w_next_state = FAULT;
                    end
                end
                FAULT: begin
                    w_next_state = FAULT;
                end
                default: begin
                    w_next_state = HOLD;
                    w_next_idx   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic, driven by the transition being taken
    // ------------------------------------------------------------------
    always_comb begin
        w_stage_reset_nxt = r_stage_reset;
        w_all_ready_nxt   = r_all_ready;
        w_fault_nxt       = r_fault;
        w_fault_stage_nxt = r_fault_stage;
        if (restart) begin
            w_stage_reset_nxt = '1;
            w_all_ready_nxt   = 1'b0;
            w_fault_nxt       = 1'b0;
            w_fault_stage_nxt = '0;
        end else if ((w_next_state == FAULT) && (r_state != FAULT)) begin
            w_stage_reset_nxt = '1;
            w_all_ready_nxt   = 1'b0;
            w_fault_nxt       = 1'b1;
            // A lost ready outranks the timeout of the stage being waited on.
            w_fault_stage_nxt = w_lost_any ? w_lost_idx : r_idx;
        end else if ((w_next_state == WAIT_READY) && (r_state != WAIT_READY)) begin
            // From HOLD idx is 0; from GAP idx already points at the stage
            // to release, so only one bit ever changes per release.
            w_stage_reset_nxt[r_idx] = 1'b0;
        end else if ((w_next_state == DONE) && (r_state != DONE)) begin
            w_all_ready_nxt = 1'b1;
        end
    end

    assign stage_reset = r_stage_reset;
    assign all_ready   = r_all_ready;
    assign fault       = r_fault;
    assign fault_stage = r_fault_stage;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer (3 stages, delay 4,
//               timeout 20). An event-based model predicts outputs every
//               cycle; literal checks pin the key release/fault cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int N = 3;
    localparam int D = 4;
    localparam int T = 20;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         restart = 1'b0;
    logic [N-1:0] stage_ready = '0;
    logic [N-1:0] stage_reset;
    logic         all_ready;
    logic         fault;
    logic [1:0]   fault_stage;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    reset_sequencer #(
        .NUM_STAGES     (N),
        .DELAY_CYCLES   (D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .restart     (restart),
        .stage_ready (stage_ready),
        .stage_reset (stage_reset),
        .all_ready   (all_ready),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    // ------------------------------------------------------------------
    // Model: since = edges since the last reset/restart edge.
    // m_rel stages released, m_acc stages accepted as ready.
    // ------------------------------------------------------------------
    int since   = 0;
    int m_rel   = 0;
    int m_acc   = 0;
    int due     = 0;
    int wstart  = 0;
    int m_fs    = 0;
    bit m_fault = 1'b0;
    bit m_all   = 1'b0;
    bit mvalid  = 1'b0;

    always @(posedge clock) begin
        int lost;
        if (reset || restart) begin
            since = 0; m_rel = 0; m_acc = 0; due = D;
            m_fault = 1'b0; m_fs = 0; m_all = 1'b0; mvalid = 1'b1;
        end else begin
            since = since + 1;
            if (!m_fault) begin
                lost = -1;
                for (int i = N - 1; i >= 0; i--) begin
                    if (i < m_acc && !stage_ready[i]) lost = i;
                end
                if (lost >= 0) begin
                    m_fault = 1'b1; m_fs = lost; m_all = 1'b0;
                end else if (m_rel == m_acc) begin
                    if (m_acc < N && since == due) begin
                        m_rel = m_rel + 1; wstart = since;
                    end
                end else if (stage_ready[m_acc]) begin
                    m_acc = m_acc + 1;
                    if (m_acc == N) m_all = 1'b1;
                    else due = since + D;
                end else if (since - wstart >= T) begin
                    m_fault = 1'b1; m_fs = m_acc;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [N-1:0] exp_sr;
        if (mvalid) begin
            for (int i = 0; i < N; i++) exp_sr[i] = m_fault || (i >= m_rel);
            tests = tests + 1;
            if (stage_reset !== exp_sr || all_ready !== m_all || fault !== m_fault ||
                fault_stage !== 2'(m_fs)) begin
                fails = fails + 1;
                $display("FAIL model since=%0d: got sr=%b ar=%b f=%b fs=%0d, expected sr=%b ar=%b f=%b fs=%0d",
                         since, stage_reset, all_ready, fault, fault_stage,
                         exp_sr, m_all, m_fault, m_fs);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s (since=%0d): got %0h, expected %0h", name, since, act, exp);
        end
    endtask

    // Advance to the negedge at which the model's edge count equals n.
    task automatic run_to(input int n);
        int guard;
        guard = 0;
        while (since != n && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (since != n) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL run_to: got since=%0d, expected %0d", since, n);
        end
    endtask

    task automatic do_restart();
        stage_ready = '0;
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        chk("restart_fault", 32'(fault), 32'd0);
        chk("restart_sr", 32'(stage_reset), 32'b111);
    endtask

    task automatic bringup(input string tag);
        run_to(3);  chk({tag, "_sr3"}, 32'(stage_reset), 32'b111);
        run_to(4);  chk({tag, "_sr4"}, 32'(stage_reset), 32'b110);
        run_to(5);  stage_ready[0] = 1'b1;
        run_to(9);  chk({tag, "_sr9"}, 32'(stage_reset), 32'b110);
        run_to(10); chk({tag, "_sr10"}, 32'(stage_reset), 32'b100);
        run_to(11); stage_ready[1] = 1'b1;
        run_to(15); chk({tag, "_sr15"}, 32'(stage_reset), 32'b100);
        run_to(16); chk({tag, "_sr16"}, 32'(stage_reset), 32'b000);
        run_to(17); stage_ready[2] = 1'b1;
        chk({tag, "_ar17"}, 32'(all_ready), 32'd0);
        run_to(18); chk({tag, "_ar18"}, 32'(all_ready), 32'd1);
        chk({tag, "_fault18"}, 32'(fault), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        repeat (2) @(negedge clock);
        chk("rst_sr", 32'(stage_reset), 32'b111);
        chk("rst_ar", 32'(all_ready), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fs", 32'(fault_stage), 32'd0);
        reset = 1'b0;

        // Normal bring-up
        bringup("boot");

        // Lost ready in DONE
        run_to(20); stage_ready[2] = 1'b0;
        run_to(21);
        chk("lost_fault", 32'(fault), 32'd1);
        chk("lost_fs", 32'(fault_stage), 32'd2);
        chk("lost_sr", 32'(stage_reset), 32'b111);
        chk("lost_ar", 32'(all_ready), 32'd0);
        stage_ready[2] = 1'b1;
        run_to(24); chk("lost_sticky", 32'(fault), 32'd1);

        // Restart recovery
        do_restart();
        bringup("rerun");

        // Timeout on stage 1
        do_restart();
        run_to(5);  stage_ready[0] = 1'b1;
        run_to(10); chk("to_sr10", 32'(stage_reset), 32'b100);
        run_to(29); chk("to_fault29", 32'(fault), 32'd0);
        run_to(30);
        chk("to_fault30", 32'(fault), 32'd1);
        chk("to_fs", 32'(fault_stage), 32'd1);
        chk("to_sr", 32'(stage_reset), 32'b111);

        // Ready on the 20th WAIT_READY edge is accepted
        do_restart();
        run_to(23); stage_ready[0] = 1'b1;
        run_to(24); chk("bnd_fault", 32'(fault), 32'd0);
        run_to(27); chk("bnd_sr27", 32'(stage_reset), 32'b110);
        run_to(28); chk("bnd_sr28", 32'(stage_reset), 32'b100);

        // Reset during GAP with idx=1; unreleased ready bits are ignored
        do_restart();
        stage_ready[0] = 1'b1;
        run_to(7);
        stage_ready = 3'b111;
        reset = 1'b1;
        @(negedge clock);
        chk("mid_sr", 32'(stage_reset), 32'b111);
        chk("mid_ar", 32'(all_ready), 32'd0);
        chk("mid_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        run_to(3);  chk("mid_sr3", 32'(stage_reset), 32'b111);
        run_to(4);  chk("mid_sr4", 32'(stage_reset), 32'b110);
        run_to(8);  chk("mid_sr8", 32'(stage_reset), 32'b110);
        run_to(9);  chk("mid_sr9", 32'(stage_reset), 32'b100);
        run_to(14); chk("mid_sr14", 32'(stage_reset), 32'b000);
        run_to(15); chk("mid_ar15", 32'(all_ready), 32'd1);

        // Released stage drops ready during GAP
        do_restart();
        stage_ready[0] = 1'b1;
        run_to(7);  stage_ready[0] = 1'b0;
        run_to(8);
        chk("gap_fault", 32'(fault), 32'd1);
        chk("gap_fs", 32'(fault_stage), 32'd0);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Ordered reset release for the subsystems behind the reset synchronizer. It takes the synchronized, de-glitched system reset and releases NUM_STAGES per-subsystem resets one at a time. Each stage must report ready before the next is released. Missing or lost ready indications are detected and force all stages back into reset.

## Interface
- NUM_STAGES, 4: number of sequenced subsystem resets; range 1..16.
- DELAY_CYCLES, 16: hold/gap length in clocks before each release; must be >= 1.
- TIMEOUT_CYCLES, 1024: clocks allowed for a released stage to assert ready; must be >= 1.
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; driven by the inverted synchronizer output.
- restart  in  1  one-cycle pulse that reruns the sequence from the start.
- stage_ready  in  NUM_STAGES  per-stage ready, synchronous to clock.
- stage_reset  out  NUM_STAGES  per-stage reset, active-high, registered.
- all_ready  out  1  high while every stage is released and ready.
- fault  out  1  sticky error flag.
- fault_stage  out  max(1,$clog2(NUM_STAGES))  index of the stage that caused fault.

## Operation
- Reset values: stage_reset all 1, all_ready 0, fault 0, fault_stage 0, state HOLD, idx 0, timer 0.
- HOLD: all stages held in reset. Count DELAY_CYCLES clocks, then clear stage_reset[0] and go to WAIT_READY with idx=0.
- WAIT_READY: timer counts up from 0.
  - stage_ready[idx]=1 and idx<NUM_STAGES-1: idx++, go to GAP.
  - stage_ready[idx]=1 and idx=NUM_STAGES-1: go to DONE and set all_ready.
  - timer reaches TIMEOUT_CYCLES without ready: go to FAULT.
- GAP: count DELAY_CYCLES clocks, then clear stage_reset[idx] and go to WAIT_READY with the timer cleared.
- DONE: all_ready=1. If any stage_ready bit drops, go to FAULT with fault_stage = lowest dropped index.
- FAULT: stage_reset all 1, all_ready 0, fault=1, fault_stage latched. Remains in FAULT until restart or reset.
- In WAIT_READY or GAP, a ready bit that drops on an already-released stage (index < idx) goes to FAULT with fault_stage = that index.
- Ready bits of stages still held in reset are ignored.
- restart in any state: next state HOLD, stage_reset all 1, all_ready 0, fault and fault_stage cleared, idx and timer 0.
- Priority: reset > restart > fault detection > ready > timeout.
- Only stage idx's reset changes per release, so stage_reset bits deassert strictly in index order and never skip.

## Timing
- Cycle 0 is the first edge at which reset is sampled low. stage_reset[0] falls after the edge ending cycle DELAY_CYCLES-1, so it is visible DELAY_CYCLES clocks after reset release.
- stage_ready[i] sampled high at edge t (i < NUM_STAGES-1): stage_reset[i+1] low after edge t+DELAY_CYCLES.
- Last stage ready at edge t: all_ready high after edge t.
- No ready by TIMEOUT_CYCLES edges after entering WAIT_READY: fault high after edge TIMEOUT_CYCLES and stage_reset all 1 on the same edge.
- Ready arriving on the same cycle as the timeout expiry is accepted; no fault is raised.
- Ready drop in DONE sampled at edge t: fault and full re-reset after edge t.
- restart sampled at edge t: outputs return to reset values after edge t, and the sequence reruns with the same timing as after reset.
- Timer width is $clog2(max(DELAY_CYCLES,TIMEOUT_CYCLES)+1) bits; it saturates and cannot wrap.

## Structure
- Shared package reset_seq_pkg holds the state typedef (HOLD, WAIT_READY, GAP, DONE, FAULT) and the timer-width function.
- One sub-module, seq_timer, holds the timer:
  - clearable up-counter with a terminal-count compare against a runtime limit;
  - the limit input selects DELAY_CYCLES or TIMEOUT_CYCLES;
  - used for both the delay and the timeout counts.
- The FSM, idx register and output registers live in reset_sequencer.

## Test plan
All scenarios use NUM_STAGES=3, DELAY_CYCLES=4, TIMEOUT_CYCLES=20.
- Normal bring-up: release reset, assert each ready 2 clocks after its stage_reset falls. stage_reset falls at cycles 4, 10 and 16; all_ready rises at cycle 18; fault stays 0.
- Timeout: never assert stage_ready[1]. fault=1 and fault_stage=1 exactly 20 clocks after stage_reset[1] falls; stage_reset returns to 3'b111.
- Ready on the timeout boundary: assert stage_ready[0] on the 20th WAIT_READY cycle. The stage is accepted, there is no fault, and the sequence continues.
- Lost ready: in DONE, drop stage_ready[2] for 1 cycle. The next edge gives fault=1, fault_stage=2, stage_reset=3'b111 and all_ready=0.
- Restart recovery: pulse restart while in FAULT. fault clears on the next edge and the timing of the normal bring-up case repeats.
- Reset mid-sequence: assert reset during GAP with idx=1. The next edge gives all outputs at reset values and idx=0; ready bits on unreleased stages have no effect.
